clk_gate_ctrl: RTL
==================

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 Parameter NUM_DOM, default 4: number of independently gated clock domains.
REQ-002 Parameter WAKE_CYCLES, default 2: clock-running cycles before a woken domain's sleep request is released (legal 1..15).
REQ-003 HCLK  input  1  system clock, ungated; all logic rising-edge.
REQ-004 HRESETn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 ENABLE  input  1  global gating enable; low forces every domain back to running.
REQ-006 TESTMODE  input  1  scan/test; forces all clock enables high.
REQ-007 IDLE_CYCLES  input  8  idle hysteresis count, sampled on entry to COUNT.
REQ-008 DOM_IDLE  input  NUM_DOM  per-domain idle indication.
REQ-009 DOM_WAKEREQ  input  NUM_DOM  per-domain wake request (from interrupt/bus logic).
REQ-010 DOM_SLEEPACK  input  NUM_DOM  per-domain acknowledge of DOM_SLEEPREQ.
REQ-011 DOM_SLEEPREQ  output  NUM_DOM  per-domain request to quiesce.
REQ-012 DOM_CLKEN  output  NUM_DOM  per-domain enable driving behavioural clock gate CLKEN.
REQ-013 DOM_GATED  output  NUM_DOM  per-domain status, high while clock is stopped.

Function
REQ-014 Each domain SHALL run an independent FSM: RUN, COUNT, SLEEPREQ, GATED, WAKE; no cross-domain interaction.
REQ-015 DOM_SLEEPREQ, DOM_GATED and internal clock enable SHALL be registered; DOM_CLKEN = clken_reg OR TESTMODE.
REQ-016 RUN: clken=1, sleepreq=0; if ENABLE & IDLE & ~WAKEREQ then go COUNT loading counter with IDLE_CYCLES, or SLEEPREQ directly when IDLE_CYCLES==0.
REQ-017 COUNT: counter decrements each cycle; ~IDLE, WAKEREQ or ~ENABLE returns to RUN; when counter==1 and still idle go SLEEPREQ (IDLE_CYCLES=N gives SLEEPREQ asserted N+1 cycles after IDLE first sampled).
REQ-018 SLEEPREQ: sleepreq=1, clken=1; on SLEEPACK go GATED; WAKEREQ or ~ENABLE before ACK aborts to RUN (sleepreq drops next cycle); abort has priority over simultaneous ACK.
REQ-019 GATED: clken=0, gated=1, sleepreq held 1; WAKEREQ or ~ENABLE moves to WAKE; DOM_IDLE ignored.
REQ-020 WAKE: clken=1, gated=0, sleepreq held 1 for WAKE_CYCLES cycles (4-bit counter), then RUN with sleepreq=0.
REQ-021 DOM_CLKEN SHALL fall exactly one cycle after SLEEPACK sampled high and rise the cycle after WAKEREQ sampled high in GATED.
REQ-022 TESTMODE SHALL NOT alter FSM state; only the DOM_CLKEN output is forced.
REQ-023 Unused FSM encodings SHALL recover to RUN next cycle.

Reset
REQ-024 Asserting HRESETn low SHALL immediately set all FSMs to RUN, DOM_CLKEN=1 (all bits), DOM_SLEEPREQ=0, DOM_GATED=0, counters 0, including mid-sleep handshake.
REQ-025 First transition after reset release SHALL occur no earlier than the first HCLK rising edge with HRESETn high.

Structure
REQ-026 State encodings (3-bit), WAKE counter width and IDLE_CYCLES width SHALL live in shared package/include clk_gate_pkg.
REQ-027 Per-domain FSM+counters SHALL be sub-module clk_gate_dom_fsm, instantiated NUM_DOM times via generate; top only fans out vectors.

Verification
REQ-028 Reset: HRESETn low mid-GATED -> DOM_CLKEN=4'hF, DOM_SLEEPREQ=0, DOM_GATED=0 asynchronously.
REQ-029 IDLE_CYCLES=3, dom0 idle, ACK 2 cycles after req -> SLEEPREQ[0] at cycle 4, CLKEN[0]=0 one cycle after ACK, GATED[0]=1; others unaffected.
REQ-030 Dom1 idle drops at COUNT cycle 2 -> back to RUN, SLEEPREQ[1] never asserted.
REQ-031 Dom2 in SLEEPREQ, WAKEREQ and ACK same cycle -> abort to RUN, CLKEN[2] stays 1.
REQ-032 Dom3 GATED, WAKEREQ pulse -> CLKEN[3]=1 next cycle, SLEEPREQ[3] low after 2 more cycles; ENABLE low wakes all gated domains identically.
REQ-033 TESTMODE=1 while dom0 GATED -> DOM_CLKEN[0]=1, DOM_GATED[0] stays 1; TESTMODE=0 restores CLKEN[0]=0.

Source files
------------

// File: rtl/clk_gate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gate_pkg
//  Description : Shared types and widths for the per-domain clock-gating
//                controller: FSM state encoding, counter widths and the
//                wake-hold load helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_gate_pkg;

    localparam int STATE_W    = 3;   // FSM state register width
    localparam int IDLE_CNT_W = 8;   // idle hysteresis counter / IDLE_CYCLES width
    localparam int WAKE_CNT_W = 4;   // wake-hold counter width

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 3'd0,
        ST_COUNT    = 3'd1,
        ST_SLEEPREQ = 3'd2,
        ST_GATED    = 3'd3,
        ST_WAKE     = 3'd4
    } dom_state_t;

    // Clamp the wake-hold length into the range the 4-bit counter can hold
    // (1..15) so an out-of-range parameter still yields a sane hold time.
    function automatic logic [WAKE_CNT_W-1:0] wake_load(input int cycles);
        int max_val;
        max_val = (1 << WAKE_CNT_W) - 1;
        if (cycles < 1) begin
            return WAKE_CNT_W'(1);
        end else if (cycles > max_val) begin
            return '1;
        end else begin
            return cycles[WAKE_CNT_W-1:0];
        end
    endfunction

endpackage : clk_gate_pkg
`default_nettype wire

// File: rtl/clk_gate_dom_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gate_dom_fsm
//  Description : Single-domain clock-gating FSM (RUN -> COUNT -> SLEEPREQ ->
//                GATED -> WAKE -> RUN) with idle hysteresis counter, sleep
//                request/acknowledge handshake and wake-hold counter.
//                All outputs are registered; testmode only forces clken.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_gate_dom_fsm
    import clk_gate_pkg::*;
#(
    parameter int WAKE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  testmode,
    input  logic [IDLE_CNT_W-1:0] idle_cycles,
    input  logic                  idle,
    input  logic                  wakereq,
    input  logic                  sleepack,
    output logic                  sleepreq,
    output logic                  clken,
    output logic                  gated
);

    localparam logic [WAKE_CNT_W-1:0] C_WAKE_LOAD = wake_load(WAKE_CYCLES);

    dom_state_t            r_state;
    logic [IDLE_CNT_W-1:0] r_idle_cnt;
    logic [WAKE_CNT_W-1:0] r_wake_cnt;
    logic                  r_sleepreq;
    logic                  r_clken;
    logic                  r_gated;

    // State, counters and registered outputs advance together in one block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
            r_sleepreq <= 1'b0;
            r_clken    <= 1'b1;
            r_gated    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_sleepreq <= 1'b0;
                    r_clken    <= 1'b1;
                    r_gated    <= 1'b0;
                    if (enable && idle && !wakereq) begin
                        if (idle_cycles == '0) begin
                            // Zero hysteresis: request sleep immediately.
                            r_state    <= ST_SLEEPREQ;
                            r_sleepreq <= 1'b1;
                        end else begin
                            r_state    <= ST_COUNT;
                            r_idle_cnt <= idle_cycles;
                        end
                    end
                end

                ST_COUNT: begin
                    if (!idle || wakereq || !enable) begin
                        r_state    <= ST_RUN;
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt <= IDLE_CNT_W'(1)) begin
                        r_state    <= ST_SLEEPREQ;
                        r_sleepreq <= 1'b1;
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt - IDLE_CNT_W'(1);
                    end
                end

                ST_SLEEPREQ: begin
                    // Abort wins over a simultaneous acknowledge.
                    if (wakereq || !enable) begin
                        r_state    <= ST_RUN;
                        r_sleepreq <= 1'b0;
                    end else if (sleepack) begin
                        r_state <= ST_GATED;
                        r_clken <= 1'b0;
                        r_gated <= 1'b1;
                    end
                end

                ST_GATED: begin
                    // Idle is irrelevant here; only a wake source restarts the clock.
                    if (wakereq || !enable) begin
                        r_state    <= ST_WAKE;
                        r_clken    <= 1'b1;
                        r_gated    <= 1'b0;
                        r_wake_cnt <= C_WAKE_LOAD;
                    end
                end

                ST_WAKE: begin
                    // Clock runs while sleepreq is still held, giving the
                    // domain settling cycles before it is released.
                    if (r_wake_cnt <= WAKE_CNT_W'(1)) begin
                        r_state    <= ST_RUN;
                        r_sleepreq <= 1'b0;
                        r_wake_cnt <= '0;
                    end else begin
                        r_wake_cnt <= r_wake_cnt - WAKE_CNT_W'(1);
                    end
                end

                default: begin
                    r_state    <= ST_RUN;
                    r_idle_cnt <= '0;
                    r_wake_cnt <= '0;
                    r_sleepreq <= 1'b0;
                    r_clken    <= 1'b1;
                    r_gated    <= 1'b0;
                end
            endcase
        end
    end

    assign sleepreq = r_sleepreq;
    assign gated    = r_gated;
    assign clken    = r_clken | testmode;

endmodule : clk_gate_dom_fsm
`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gate_ctrl
//  Description : Multi-domain clock-gating controller. Fans the shared
//                controls and per-domain vectors out to NUM_DOM independent
//                clk_gate_dom_fsm instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int NUM_DOM     = 4,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  ENABLE,
    input  logic                  TESTMODE,
    input  logic [IDLE_CNT_W-1:0] IDLE_CYCLES,
    input  logic [NUM_DOM-1:0]    DOM_IDLE,
    input  logic [NUM_DOM-1:0]    DOM_WAKEREQ,
    input  logic [NUM_DOM-1:0]    DOM_SLEEPACK,
    output logic [NUM_DOM-1:0]    DOM_SLEEPREQ,
    output logic [NUM_DOM-1:0]    DOM_CLKEN,
    output logic [NUM_DOM-1:0]    DOM_GATED
);

    genvar g_idx;
    generate
        for (g_idx = 0; g_idx < NUM_DOM; g_idx++) begin : g_dom
            clk_gate_dom_fsm #(
                .WAKE_CYCLES (WAKE_CYCLES)
            ) u_dom_fsm (
                .clk         (HCLK),
                .rst_n       (HRESETn),
                .enable      (ENABLE),
                .testmode    (TESTMODE),
                .idle_cycles (IDLE_CYCLES),
                .idle        (DOM_IDLE[g_idx]),
                .wakereq     (DOM_WAKEREQ[g_idx]),
                .sleepack    (DOM_SLEEPACK[g_idx]),
                .sleepreq    (DOM_SLEEPREQ[g_idx]),
                .clken       (DOM_CLKEN[g_idx]),
                .gated       (DOM_GATED[g_idx])
            );
        end
    endgenerate

endmodule : clk_gate_ctrl
`default_nettype wire
